// File: rtl/fetch_sequencer.sv
// Multi-cycle front end: fetches instructions over a req/ack handshake, owns the PC and
// sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK for the decode stage downstream.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr_o,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic        imem_err_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ir_o,
  output logic [2:0]  stage_o,
  output logic [31:0] pc_o,
  input  logic        pc_load_i,
  input  logic [31:0] pc_target_i,
  input  logic        mem_done_i,
  output logic        wb_strobe_o,
  output logic        fault_o,
  input  logic        halt_i
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_FAULT     = 3'd7
  } stage_e;

  localparam int unsigned CNT_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam bit          TMO_EN   = (FETCH_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (FETCH_TIMEOUT == 0) ? '0 : CNT_W'(FETCH_TIMEOUT - 1);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  stage_e           stage_q;
  logic [31:0]      pc_q;
  logic [31:0]      ir_q;
  logic [31:0]      next_pc_q;
  logic             req_q;
  logic             wb_q;
  logic             fault_q;
  logic [CNT_W-1:0] wait_cnt_q;

  logic is_load;
  logic is_store;
  logic is_mem;
  logic rd_nonzero;
  logic unused_target_lsb;

  assign is_load           = (ir_q[6:0] == OP_LOAD);
  assign is_store          = (ir_q[6:0] == OP_STORE);
  assign is_mem            = is_load | is_store;
  assign rd_nonzero        = (ir_q[11:7] != 5'd0);
  assign unused_target_lsb = ^pc_target_i[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      req_q      <= 1'b0;
      wb_q       <= 1'b0;
      fault_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      case (stage_q)
        // FETCH: a request cycle with req low only raises req (first fetch after reset)
        ST_FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem_err_i) begin
            stage_q <= ST_FAULT;
            req_q   <= 1'b0;
            fault_q <= 1'b1;
          end else if (imem_ack_i) begin
            ir_q       <= imem_rdata_i;
            req_q      <= 1'b0;
            wait_cnt_q <= '0;
            stage_q    <= ST_DECODE;
          end else if (TMO_EN && (wait_cnt_q == CNT_LAST)) begin
            stage_q <= ST_FAULT;
            req_q   <= 1'b0;
            fault_q <= 1'b1;
          end else if (TMO_EN) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        // DECODE
        ST_DECODE: begin
          stage_q <= ST_EXECUTE;
        end
        // EXECUTE: redirect target captured by the data register below
        ST_EXECUTE: begin
          stage_q <= ST_MEMORY;
        end
        // MEMORY: loads and stores wait for the data side, others pass through
        ST_MEMORY: begin
          if (!is_mem || mem_done_i) begin
            stage_q <= ST_WRITEBACK;
            wb_q    <= !is_store && rd_nonzero;
          end
        end
        // WRITEBACK: strobe lasts one cycle even if halt holds us here
        ST_WRITEBACK: begin
          wb_q <= 1'b0;
          if (!halt_i) begin
            stage_q    <= ST_FETCH;
            req_q      <= 1'b1;
            pc_q       <= next_pc_q;
            wait_cnt_q <= '0;
          end
        end
        // FAULT: absorbing until reset
        ST_FAULT: begin
          req_q   <= 1'b0;
          wb_q    <= 1'b0;
          fault_q <= 1'b1;
        end
        default: begin
          stage_q <= ST_FAULT;
          req_q   <= 1'b0;
          wb_q    <= 1'b0;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (stage_q == ST_EXECUTE) begin
      next_pc_q <= pc_load_i ? {pc_target_i[31:2], 2'b00} : pc_q + 32'd4;
    end
  end

  assign imem_addr_o = pc_q;
  assign imem_req_o  = req_q;
  assign ir_o        = ir_q;
  assign stage_o     = stage_q;
  assign pc_o        = pc_q;
  assign wb_strobe_o = wb_q;
  assign fault_o     = fault_q;

endmodule
